// File: rtl/quad_pkg.sv
// Shared types and the quadrature transition classifier
// used by the A/B encoder decoder.
package quad_pkg;

    typedef logic [1:0] quad_state_t;

    localparam quad_state_t Q00 = 2'b00;
    localparam quad_state_t Q10 = 2'b10;
    localparam quad_state_t Q11 = 2'b11;
    localparam quad_state_t Q01 = 2'b01;

    typedef enum logic [1:0] {
        QS_NONE,
        QS_UP,
        QS_DOWN,
        QS_ILLEGAL
    } step_kind_t;

    function automatic quad_state_t quad_next_up(input quad_state_t cur);
        quad_state_t nxt;
        unique case (cur)
            Q00:     nxt = Q10;
            Q10:     nxt = Q11;
            Q11:     nxt = Q01;
            default: nxt = Q00;
        endcase
        return nxt;
    endfunction

    // Gray-code sequence: one bit flip is a legal step, two flips is illegal.
    function automatic step_kind_t quad_step(
        input quad_state_t prev,
        input quad_state_t cur
    );
        step_kind_t kind;
        if (prev == cur)
            kind = QS_NONE;
        else if ((prev ^ cur) == 2'b11)
            kind = QS_ILLEGAL;
        else if (quad_next_up(prev) == cur)
            kind = QS_UP;
        else
            kind = QS_DOWN;
        return kind;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for one asynchronous input bit,
// cleared to 0 by synchronous reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk) begin
        if (rst)
            sync_q <= '0;
        else
            sync_q <= sync_d;
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// 4x quadrature decoder: synchronizes A/B, emits step/dir,
// keeps a wrapping position count and a sticky illegal-move flag.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic             step,
    output logic             dir,
    output logic [WIDTH-1:0] pos,
    output logic             err
);

    localparam logic [1:0] FILL_DONE = 2'(SYNC_STAGES);

    logic        a_sync;
    logic        b_sync;
    quad_state_t s;
    step_kind_t  kind;

    quad_state_t      prev_q,   prev_d;
    logic             primed_q, primed_d;
    logic [1:0]       fill_q,   fill_d;
    logic             step_q,   step_d;
    logic             dir_q,    dir_d;
    logic [WIDTH-1:0] pos_q,    pos_d;
    logic             err_q,    err_d;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk (clk),
        .rst (rst),
        .d_i (a_in),
        .q_o (a_sync)
    );

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk (clk),
        .rst (rst),
        .d_i (b_in),
        .q_o (b_sync)
    );

    assign s    = {a_sync, b_sync};
    assign kind = quad_step(prev_q, s);

    always_comb begin
        prev_d   = prev_q;
        primed_d = primed_q;
        fill_d   = fill_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        pos_d    = pos_q;
        err_d    = err_q;

        if (clr_err)
            err_d = 1'b0;

        // Wait until the synchronizers hold real pin values, then seed prev.
        if (!primed_q) begin
            if (fill_q == FILL_DONE) begin
                primed_d = 1'b1;
                prev_d   = s;
            end else begin
                fill_d = fill_q + 2'd1;
            end
        end else begin
            prev_d = s;
            unique case (kind)
                QS_UP: begin
                    step_d = 1'b1;
                    dir_d  = 1'b1;
                    pos_d  = pos_q + WIDTH'(1);
                end
                QS_DOWN: begin
                    step_d = 1'b1;
                    dir_d  = 1'b0;
                    pos_d  = pos_q - WIDTH'(1);
                end
                QS_ILLEGAL: err_d = 1'b1;
                default: ;
            endcase
        end

        if (load)
            pos_d = load_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= Q00;
            primed_q <= 1'b0;
            fill_q   <= 2'd0;
            step_q   <= 1'b0;
            dir_q    <= 1'b1;
            pos_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
            fill_q   <= fill_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            pos_q    <= pos_d;
            err_q    <= err_d;
        end
    end

    assign step = step_q;
    assign dir  = dir_q;
    assign pos  = pos_q;
    assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: a table of encoder moves
// plus hand sequences for latency, clr/set, load and reset.
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_in;
    logic       b_in;
    logic       load;
    logic [7:0] load_val;
    logic       clr_err;
    logic       step;
    logic       dir;
    logic [7:0] pos;
    logic       err;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       a;
        logic       b;
        int         steps;
        logic       dir;
        logic [7:0] pos;
        logic       err;
    } vec_t;

    vec_t tbl[11];

    quad_decoder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .b_in     (b_in),
        .load     (load),
        .load_val (load_val),
        .clr_err  (clr_err),
        .step     (step),
        .dir      (dir),
        .pos      (pos),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one move, watch 4 edges, check pulse count/width and state.
    task automatic apply(input string nm, input logic a, input logic b,
                         input int esteps, input logic edir,
                         input logic [7:0] epos, input logic eerr);
        int   cnt;
        int   dbl;
        logic last;
        cnt  = 0;
        dbl  = 0;
        last = 1'b0;
        @(negedge clk);
        a_in = a;
        b_in = b;
        repeat (4) begin
            tick();
            if (step === 1'b1) begin
                cnt++;
                if (last) dbl++;
            end
            last = step;
        end
        chk({nm, " steps"}, cnt, esteps);
        chk({nm, " width"}, dbl, 0);
        chk({nm, " dir"}, {31'd0, dir}, {31'd0, edir});
        chk({nm, " pos"}, {24'd0, pos}, {24'd0, epos});
        chk({nm, " err"}, {31'd0, err}, {31'd0, eerr});
    endtask

    task automatic count_idle(input string nm, input int n);
        int cnt;
        cnt = 0;
        repeat (n) begin
            tick();
            if (step !== 1'b0) cnt++;
        end
        chk({nm, " no step"}, cnt, 0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1, 1'b1, 8'd1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1, 1'b1, 8'd2, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1, 1'b1, 8'd3, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1, 1'b1, 8'd4, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1, 1'b0, 8'd3, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1, 1'b1, 8'd4, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1, 1'b1, 8'd5, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 0, 1'b1, 8'd5, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1, 1'b1, 8'd6, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1, 1'b1, 8'd7, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1, 1'b1, 8'd8, 1'b1};

        rst      = 1'b1;
        a_in     = 1'b1;
        b_in     = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;
        clr_err  = 1'b0;

        // Reset and priming with pins held at 11
        repeat (3) tick();
        chk("rst step", {31'd0, step}, 0);
        chk("rst dir", {31'd0, dir}, 1);
        chk("rst pos", {24'd0, pos}, 0);
        chk("rst err", {31'd0, err}, 0);
        @(negedge clk);
        rst = 1'b0;
        count_idle("prime", 8);
        chk("prime pos", {24'd0, pos}, 0);
        chk("prime err", {31'd0, err}, 0);

        for (int i = 0; i < 11; i++)
            apply($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
                  tbl[i].steps, tbl[i].dir, tbl[i].pos, tbl[i].err);

        // First pulse latency: 00 -> 10
        @(negedge clk);
        a_in = 1'b1;
        b_in = 1'b0;
        tick();
        chk("lat e0", {31'd0, step}, 0);
        tick();
        chk("lat e1", {31'd0, step}, 0);
        tick();
        chk("lat e2", {31'd0, step}, 1);
        chk("lat pos", {24'd0, pos}, 9);
        tick();
        chk("lat e3", {31'd0, step}, 0);

        apply("fw11", 1'b1, 1'b1, 1, 1'b1, 8'd10, 1'b1);
        apply("fw01", 1'b0, 1'b1, 1, 1'b1, 8'd11, 1'b1);
        apply("fw00", 1'b0, 1'b0, 1, 1'b1, 8'd12, 1'b1);

        // Plain clear
        @(negedge clk);
        clr_err = 1'b1;
        tick();
        chk("clr err", {31'd0, err}, 0);
        @(negedge clk);
        clr_err = 1'b0;

        // Clear colliding with 00 -> 11: set wins
        a_in = 1'b1;
        b_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clr_err = 1'b1;
        tick();
        chk("clrset err", {31'd0, err}, 1);
        chk("clrset step", {31'd0, step}, 0);
        chk("clrset pos", {24'd0, pos}, 12);
        @(negedge clk);
        clr_err = 1'b0;
        repeat (2) tick();

        apply("dn10", 1'b1, 1'b0, 1, 1'b0, 8'd11, 1'b1);
        apply("dn00", 1'b0, 1'b0, 1, 1'b0, 8'd10, 1'b1);
        @(negedge clk);
        clr_err  = 1'b1;
        load     = 1'b1;
        load_val = 8'h00;
        tick();
        chk("ld0 pos", {24'd0, pos}, 0);
        chk("ld0 err", {31'd0, err}, 0);
        @(negedge clk);
        clr_err = 1'b0;
        load    = 1'b0;

        // Reverse through zero
        apply("wrap01", 1'b0, 1'b1, 1, 1'b0, 8'hFF, 1'b0);
        apply("wrap11", 1'b1, 1'b1, 1, 1'b0, 8'hFE, 1'b0);

        // Load on the same edge as an up step (11 -> 01)
        @(negedge clk);
        a_in = 1'b0;
        b_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        load     = 1'b1;
        load_val = 8'h40;
        tick();
        chk("ldcol step", {31'd0, step}, 1);
        chk("ldcol dir", {31'd0, dir}, 1);
        chk("ldcol pos", {24'd0, pos}, 8'h40);
        @(negedge clk);
        load = 1'b0;
        tick();
        chk("ldcol hold", {24'd0, pos}, 8'h40);

        // Reset mid-count with pins moving and load ignored
        @(negedge clk);
        load     = 1'b1;
        load_val = 8'h23;
        tick();
        chk("ld23 pos", {24'd0, pos}, 8'h23);
        @(negedge clk);
        load_val = 8'h55;
        rst      = 1'b1;
        a_in     = 1'b0;
        b_in     = 1'b0;
        tick();
        chk("mrst pos", {24'd0, pos}, 0);
        chk("mrst step", {31'd0, step}, 0);
        chk("mrst dir", {31'd0, dir}, 1);
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        a_in = 1'b1;
        b_in = 1'b0;
        count_idle("reprime", 8);
        chk("reprime pos", {24'd0, pos}, 0);
        chk("reprime err", {31'd0, err}, 0);
        apply("after", 1'b1, 1'b1, 1, 1'b1, 8'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
